// File: rtl/crc_stream_defs_pkg.sv
// Shared definitions for the CRC stream peripheral: register addresses,
// STATUS bit positions, engine state encoding and FIFO entry layout.
package crc_stream_defs_pkg;

  localparam logic [3:0] A_DATA16 = 4'h0;
  localparam logic [3:0] A_DATA8  = 4'h2;
  localparam logic [3:0] A_CTRL   = 4'h4;
  localparam logic [3:0] A_STATUS = 4'h6;
  localparam logic [3:0] A_CRC_LO = 4'h8;
  localparam logic [3:0] A_CRC_HI = 4'hA;
  localparam logic [3:0] A_COUNT  = 4'hC;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_DONE  = 4;

  typedef enum logic {
    ENG_IDLE  = 1'b0,
    ENG_SHIFT = 1'b1
  } eng_state_t;

  // len8 marks a DATA8 entry; its payload sits in data[7:0]
  typedef struct packed {
    logic        len8;
    logic [15:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/crc_serial_engine.sv
// Bit-serial MSB-first CRC engine: pops one FIFO entry when idle and folds
// 8 or 16 bits into the running CRC, one bit per clock.
module crc_serial_engine
  import crc_stream_defs_pkg::*;
#(
  parameter int          CRC_W = 7,
  parameter logic [31:0] POLY  = 32'h0000_0009,
  parameter logic [31:0] INIT  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  // Handshake: an entry transfers on a clock edge where in_valid && in_ready.
  // in_ready is high only in IDLE and never while clear is asserted.
  input  logic             in_valid,
  output logic             in_ready,
  input  fifo_entry_t      in_entry,
  output logic [CRC_W-1:0] crc,
  output logic [15:0]      count,
  output logic             busy,
  output eng_state_t       state
);

  localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];

  eng_state_t       state_q, state_d;
  logic [15:0]      sr_q, sr_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic             len8_q, len8_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [15:0]      count_q, count_d;
  logic [CRC_W-1:0] crc_sh;
  logic             fb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ENG_IDLE;
      sr_q     <= '0;
      bitcnt_q <= '0;
      len8_q   <= 1'b0;
      crc_q    <= INIT_W;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      len8_q   <= len8_d;
      crc_q    <= crc_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    len8_d   = len8_q;
    crc_d    = crc_q;
    count_d  = count_q;
    fb       = 1'b0;
    crc_sh   = crc_q << 1;
    in_ready = (state_q == ENG_IDLE) && !clear;

    if (clear) begin
      // Abort any in-flight entry and restart from the seed value
      state_d  = ENG_IDLE;
      sr_d     = '0;
      bitcnt_d = '0;
      len8_d   = 1'b0;
      crc_d    = INIT_W;
      count_d  = '0;
    end else begin
      case (state_q)
        ENG_IDLE: begin
          if (in_valid) begin
            sr_d     = in_entry.len8 ? {in_entry.data[7:0], 8'h00} : in_entry.data;
            bitcnt_d = in_entry.len8 ? 4'd7 : 4'd15;
            len8_d   = in_entry.len8;
            state_d  = ENG_SHIFT;
          end
        end
        ENG_SHIFT: begin
          fb    = crc_q[CRC_W-1] ^ sr_q[15];
          crc_d = crc_sh ^ (fb ? POLY_W : '0);
          sr_d  = sr_q << 1;
          if (bitcnt_q == 4'd0) begin
            count_d = count_q + (len8_q ? 16'd1 : 16'd2);
            state_d = ENG_IDLE;
          end else begin
            bitcnt_d = bitcnt_q - 4'd1;
          end
        end
        default: state_d = ENG_IDLE;
      endcase
    end
  end

  assign crc   = crc_q;
  assign count = count_q;
  assign busy  = (state_q == ENG_SHIFT);
  assign state = state_q;

endmodule

// File: rtl/peripheral_crc_stream.sv
// Memory-mapped CRC stream peripheral for the J1 I/O bus: register decode,
// input FIFO with sticky overflow, and a bit-serial CRC engine.
module peripheral_crc_stream
  import crc_stream_defs_pkg::*;
#(
  parameter int          CRC_W      = 7,
  parameter logic [31:0] POLY       = 32'h0000_0009,
  parameter logic [31:0] INIT       = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  fifo_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             ovf;
  logic             empty, full;
  logic             wr_en, rd_en, data_wr, init, push, pop, ovf_set;
  fifo_entry_t      new_entry;
  logic             eng_ready, busy, done;
  eng_state_t       eng_state;
  logic [CRC_W-1:0] crc;
  logic [15:0]      count;
  logic [31:0]      crc_ext;

  assign wr_en   = cs && wr;
  assign rd_en   = cs && rd;
  assign data_wr = wr_en && ((addr == A_DATA16) || (addr == A_DATA8));
  assign init    = wr_en && (addr == A_CTRL) && d_in[0];

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // INIT beats a same-cycle push: the word is discarded without flagging ovf
  assign pop     = !empty && eng_ready;
  assign push    = data_wr && !init && (!full || pop);
  assign ovf_set = data_wr && !init && full && !pop;

  assign new_entry = {(addr == A_DATA8), d_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (init) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set) ovf    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= new_entry;
  end

  crc_serial_engine #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .INIT  (INIT)
  ) u_engine (
    .clk      (clk),
    .rst      (rst),
    .clear    (init),
    .in_valid (!empty),
    .in_ready (eng_ready),
    .in_entry (mem[rd_ptr[PTR_W-1:0]]),
    .crc      (crc),
    .count    (count),
    .busy     (busy),
    .state    (eng_state)
  );

  assign done = (eng_state == ENG_IDLE) && empty;

  always_comb begin
    crc_ext            = '0;
    crc_ext[CRC_W-1:0] = crc;
  end

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        A_STATUS: begin
          d_out[ST_BUSY]  = busy;
          d_out[ST_EMPTY] = empty;
          d_out[ST_FULL]  = full;
          d_out[ST_OVF]   = ovf;
          d_out[ST_DONE]  = done;
        end
        A_CRC_LO: d_out = crc_ext[15:0];
        A_CRC_HI: d_out = crc_ext[31:16];
        A_COUNT:  d_out = count;
        default:  d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_crc_stream.sv
// Bench for peripheral_crc_stream: three parameterisations share one bus,
// a byte-level CRC model predicts register contents, a monitor scores reads.
module tb_peripheral_crc_stream;
  import crc_stream_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs0, cs1, cs2;
  logic        rd, wr;
  logic [3:0]  addr;
  logic [15:0] d_in;
  logic [15:0] d0, d1, d2;

  int          sel;
  bit          chk;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];

  int          mw[3]    = '{7, 16, 32};
  logic [31:0] mpoly[3] = '{32'h09, 32'h1021, 32'h04C1_1DB7};
  logic [31:0] minit[3] = '{32'h0, 32'h0, 32'hFFFF_FFFF};
  logic [31:0] mcrc[3];
  logic [15:0] mcnt[3];
  bit          movf[3];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  peripheral_crc_stream #(.CRC_W(7), .POLY(32'h09), .INIT(32'h0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs0), .addr(addr), .rd(rd), .wr(wr), .d_out(d0));
  peripheral_crc_stream #(.CRC_W(16), .POLY(32'h1021), .INIT(32'h0), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs1), .addr(addr), .rd(rd), .wr(wr), .d_out(d1));
  peripheral_crc_stream #(.CRC_W(32), .POLY(32'h04C1_1DB7), .INIT(32'hFFFF_FFFF), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs2), .addr(addr), .rd(rd), .wr(wr), .d_out(d2));

  // reference model: textbook MSB-first CRC over the accepted byte stream
  function automatic logic [31:0] crc_byte(logic [31:0] c, logic [7:0] b, int w, logic [31:0] p);
    logic [31:0] mask;
    logic        fb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    for (int i = 7; i >= 0; i--) begin
      fb = c[w-1] ^ b[i];
      c  = ((c << 1) ^ (fb ? p : 32'h0)) & mask;
    end
    return c;
  endfunction

  task automatic model_init(int d);
    mcrc[d] = minit[d];
    mcnt[d] = 16'h0;
    movf[d] = 1'b0;
  endtask

  task automatic model_push(int d, bit is8, logic [15:0] v);
    if (is8) begin
      mcrc[d] = crc_byte(mcrc[d], v[7:0], mw[d], mpoly[d]);
      mcnt[d] = mcnt[d] + 16'd1;
    end else begin
      mcrc[d] = crc_byte(mcrc[d], v[15:8], mw[d], mpoly[d]);
      mcrc[d] = crc_byte(mcrc[d], v[7:0], mw[d], mpoly[d]);
      mcnt[d] = mcnt[d] + 16'd2;
    end
  endtask

  // driver tasks: entered and left at posedge+1
  task automatic set_cs(int d);
    cs0 = (d == 0);
    cs1 = (d == 1);
    cs2 = (d == 2);
  endtask

  task automatic bus_idle();
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    rd  = 1'b0; wr  = 1'b0; chk = 1'b0;
  endtask

  task automatic bus_write(int d, logic [3:0] a, logic [15:0] v);
    sel = d; set_cs(d);
    wr = 1'b1; addr = a; d_in = v;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic push_data(int d, bit is8, logic [15:0] v, bit accepted);
    bus_write(d, is8 ? A_DATA8 : A_DATA16, v);
    if (accepted) model_push(d, is8, v);
  endtask

  task automatic scored_access(int d, logic [3:0] a, bit do_rd, logic [15:0] e, string nm);
    sel = d; set_cs(d);
    rd = do_rd; addr = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk = 1'b1;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic scored_read(int d, logic [3:0] a, logic [15:0] e, string nm);
    scored_access(d, a, 1'b1, e, nm);
  endtask

  task automatic raw_read(int d, logic [3:0] a, output logic [15:0] v);
    sel = d; set_cs(d);
    rd = 1'b1; addr = a;
    @(negedge clk);
    v = (d == 0) ? d0 : (d == 1) ? d1 : d2;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic wait_done(int d);
    logic [15:0] v;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      raw_read(d, A_STATUS, v);
      if (v[ST_DONE]) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_done dut%0d: done still 0 after 400 polls, required 1", d);
    end
  endtask

  task automatic expect_regs(int d, string tag);
    scored_read(d, A_STATUS, {11'b0, 1'b1, movf[d], 1'b0, 1'b1, 1'b0}, {tag, "_status"});
    scored_read(d, A_CRC_LO, mcrc[d][15:0], {tag, "_crc_lo"});
    scored_read(d, A_CRC_HI, mcrc[d][31:16], {tag, "_crc_hi"});
    scored_read(d, A_COUNT, mcnt[d], {tag, "_count"});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [15:0] got, e;
    string nm;
    if (chk) begin
      got = (sel == 0) ? d0 : (sel == 1) ? d1 : d2;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: read value %h with no expected entry", got);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL %s dut%0d: got %h required %h", nm, sel, got, e);
        end
      end
    end
  end

  logic [15:0] w16[4] = '{16'h3132, 16'h3334, 16'h3536, 16'h3738};

  initial begin
    int d, n;
    bit is8;
    logic [15:0] v;

    bus_idle();
    sel = 0; addr = '0; d_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) model_init(i);

    for (int i = 0; i < 3; i++) expect_regs(i, "reset");

    // "123456789" on CRC-7 and CRC-16/XMODEM
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) push_data(k, 1'b0, w16[i], 1'b1);
      push_data(k, 1'b1, 16'h0039, 1'b1);
    end
    wait_done(0);
    scored_read(0, A_CRC_LO, 16'h0075, "t1_crc7");
    scored_read(0, A_COUNT, 16'd9, "t1_count");
    wait_done(1);
    scored_read(1, A_CRC_LO, 16'h31C3, "t2_crc16_lo");
    scored_read(1, A_CRC_HI, 16'h0000, "t2_crc16_hi");
    scored_read(1, A_COUNT, 16'd9, "t2_count");

    // CRC-32 seed with one zero byte, plus unlisted reads
    push_data(2, 1'b1, 16'hA500, 1'b1);
    wait_done(2);
    expect_regs(2, "t6");
    scored_read(2, 4'hE, 16'h0000, "t6_addr_e");
    scored_read(2, 4'hF, 16'h0000, "t6_addr_f");

    // ignored writes and d_out gating
    bus_write(0, 4'h1, 16'hABCD);
    bus_write(0, A_STATUS, 16'hFFFF);
    bus_write(0, A_CTRL, 16'hFFFE);
    expect_regs(0, "unlisted_wr");
    scored_access(0, A_CRC_LO, 1'b0, 16'h0000, "no_rd_zero");

    // overflow: one word goes straight to the engine, FIFO takes four more
    bus_write(0, A_CTRL, 16'h0001);
    model_init(0);
    for (int i = 0; i < 6; i++) push_data(0, 1'b0, 16'($urandom), i < 5);
    movf[0] = 1'b1;
    scored_read(0, A_STATUS, {11'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}, "t3_full_ovf");
    wait_done(0);
    expect_regs(0, "t3");

    // INIT while shifting with two entries queued
    for (int i = 0; i < 3; i++) push_data(0, 1'b0, 16'($urandom), 1'b1);
    @(posedge clk); #1;
    bus_write(0, A_CTRL, 16'h0001);
    model_init(0);
    expect_regs(0, "t4");

    // asynchronous reset pulse while busy
    push_data(0, 1'b0, 16'($urandom), 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    sel = 0; set_cs(0); rd = 1'b1; addr = A_STATUS;
    exp_q.push_back(16'h0012);
    name_q.push_back("t5_async_rst_status");
    chk = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    bus_idle();
    for (int i = 0; i < 3; i++) model_init(i);
    expect_regs(0, "t5");

    // randomized bursts
    for (int r = 0; r < 15; r++) begin
      d = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        bus_write(d, A_CTRL, 16'h0001);
        model_init(d);
      end
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        is8 = 1'($urandom_range(0, 1));
        v   = 16'($urandom);
        push_data(d, is8, v, 1'b1);
      end
      wait_done(d);
      expect_regs(d, "rand");
    end

    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
